// File: rtl/mul_div_pkg.sv
// Shared definitions for the shift-add multiplier and the non-restoring divider:
// default operand width and the sequencing FSM state encoding.
package mul_div_pkg;

    // Default operand width shared by multiplier, divider and their checkers.
    localparam int MUL_WIDTH = 4;

    // Sequencing states of the multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage

// File: rtl/addsub_wp1.sv
// Ripple-carry add/subtract built from full-adder cells.
// m = 0: s = a + b ; m = 1: s = a - b (two's complement, carry-in = 1).
import mul_div_pkg::*;

module addsub_wp1 #(
    parameter int W = MUL_WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0]   carry_s;
    logic [W-1:0] b_eff_s;

    assign b_eff_s    = b ^ {W{m}};
    assign carry_s[0] = m;

    generate
        for (genvar i = 0; i < W; i++) begin : g_fa
            assign s[i]           = a[i] ^ b_eff_s[i] ^ carry_s[i];
            assign carry_s[i + 1] = (a[i] & b_eff_s[i]) | (carry_s[i] & (a[i] ^ b_eff_s[i]));
        end
    endgenerate

    assign cout = carry_s[W];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier, P = A*B (+ C).
// One multiplier bit per clock through a single (WIDTH+1)-bit ripple adder.
// Optional feature macro: MUL_ADDEND_EN adds the final addend cycle (P = A*B + C).
import mul_div_pkg::*;

module shift_add_multiplier #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]           rst_sync_r;
    logic                 rst_int_n_s;

    mul_state_e           state_r;
    mul_state_e           state_nxt_s;

    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH:0]       hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   p_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       add_a_s;
    logic [WIDTH:0]       add_b_s;
    logic [WIDTH:0]       add_sum_s;
    logic                 add_cout_s;
    logic [WIDTH:0]       step_sum_s;
    logic [WIDTH:0]       step_hi_s;
    logic [WIDTH-1:0]     step_lo_s;
    logic                 last_step_s;
    logic                 unused_s;

`ifdef MUL_ADDEND_EN
    logic [WIDTH-1:0]     addend_r;
    logic [2*WIDTH-1:0]   acc_sum_s;
`endif

    // Reset synchronizer: assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Partial-product adder; the carry lands in sum[WIDTH] and hence in hi's MSB before the shift.
    assign add_a_s = {1'b0, hi_r[WIDTH-1:0]};
    assign add_b_s = {1'b0, mcand_r};

    addsub_wp1 #(
        .W (WIDTH + 1)
    ) u_addsub (
        .a    (add_a_s),
        .b    (add_b_s),
        .m    (1'b0),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // One step: conditionally add, then shift {carry, sum, lo} right by one.
    assign step_sum_s  = lo_r[0] ? add_sum_s : add_a_s;
    assign step_hi_s   = {1'b0, step_sum_s[WIDTH:1]};
    assign step_lo_s   = {step_sum_s[0], lo_r[WIDTH-1:1]};
    assign last_step_s = (cnt_r == CNT_W'(WIDTH - 1));

`ifdef MUL_ADDEND_EN
    // Final addend cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
    assign acc_sum_s = {hi_r[WIDTH-1:0], lo_r} + {{WIDTH{1'b0}}, addend_r};
    assign unused_s  = ^{add_cout_s, hi_r[WIDTH]};
`else
    assign unused_s  = ^{add_cout_s, hi_r[WIDTH], C};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (last_step_s) begin
`ifdef MUL_ADDEND_EN
                    state_nxt_s = ADD;
`else
                    state_nxt_s = DONE;
`endif
                end else begin
                    state_nxt_s = MUL;
                end
            end
            ADD: begin
`ifdef MUL_ADDEND_EN
                state_nxt_s = DONE;
`else
                state_nxt_s = IDLE;
`endif
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath: operand load, shift-add steps, addend cycle and result capture.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            mcand_r  <= {WIDTH{1'b0}};
            hi_r     <= {(WIDTH + 1){1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            p_r      <= {(2 * WIDTH){1'b0}};
`ifdef MUL_ADDEND_EN
            addend_r <= {WIDTH{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_r  <= A;
                        lo_r     <= B;
                        hi_r     <= {(WIDTH + 1){1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
`ifdef MUL_ADDEND_EN
                        addend_r <= C;
`endif
                    end
                end
                MUL: begin
                    hi_r  <= step_hi_s;
                    lo_r  <= step_lo_s;
                    cnt_r <= cnt_r + CNT_W'(1);
`ifndef MUL_ADDEND_EN
                    if (last_step_s) begin
                        p_r <= {step_hi_s[WIDTH-1:0], step_lo_s};
                    end
`endif
                end
`ifdef MUL_ADDEND_EN
                ADD: begin
                    hi_r[WIDTH-1:0] <= acc_sum_s[2*WIDTH-1:WIDTH];
                    lo_r            <= acc_sum_s[WIDTH-1:0];
                    p_r             <= acc_sum_s;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Registered handshake outputs derived from the state being entered.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == MUL) || (state_nxt_s == ADD);
            done_r <= (state_nxt_s == DONE);
        end
    end

    assign P    = p_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
